// File: rtl/fan_ctrl_pkg.sv
// Shared encodings and default thresholds for the fan speed controller.
package fan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SAMPLE   = 3'd1,
    ST_APPLY    = 3'd2,
    ST_OVERRIDE = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    SPEED_OFF  = 2'd0,
    SPEED_LOW  = 2'd1,
    SPEED_MED  = 2'd2,
    SPEED_HIGH = 2'd3
  } speed_e;

  localparam int DEF_LOW_MAX_DELTA = 4;
  localparam int DEF_MED_MAX_DELTA = 9;

  typedef struct packed {
    logic [6:0] reading;
    logic [6:0] setpoint;
    logic       ovr;
    logic       ovr_speed;
  } sample_t;

  function automatic speed_e override_code(input logic ovr_speed);
    return ovr_speed ? SPEED_HIGH : SPEED_OFF;
  endfunction

endpackage

// File: rtl/fan_speed_decode.sv
// Combinational map from (reading, setpoint, override) to a fan speed code.
module fan_speed_decode
  import fan_ctrl_pkg::*;
#(
  parameter int LOW_MAX_DELTA = DEF_LOW_MAX_DELTA,
  parameter int MED_MAX_DELTA = DEF_MED_MAX_DELTA
) (
  input  logic [6:0] reading_i,
  input  logic [6:0] setpoint_i,
  input  logic       override_i,
  input  logic       override_speed_i,
  output speed_e     speed_o
);

  localparam logic signed [7:0] LOW_T = 8'(LOW_MAX_DELTA);
  localparam logic signed [7:0] MED_T = 8'(MED_MAX_DELTA);

  // Zero-extended 7-bit operands cannot overflow an 8-bit signed difference.
  logic signed [7:0] delta;
  assign delta = $signed({1'b0, reading_i}) - $signed({1'b0, setpoint_i});

  always_comb begin
    speed_o = SPEED_OFF;
    if (override_i) begin
      speed_o = override_code(override_speed_i);
    end else if (delta <= 8'sd0) begin
      speed_o = SPEED_OFF;
    end else if (delta <= LOW_T) begin
      speed_o = SPEED_LOW;
    end else if (delta <= MED_T) begin
      speed_o = SPEED_MED;
    end else begin
      speed_o = SPEED_HIGH;
    end
  end

endmodule

// File: rtl/fan_speed_controller.sv
// Closed-loop fan speed controller: samples temperature/override inputs and
// refreshes the registered fan speed every two cycles.
//
//   state    | meaning
//   IDLE     | first cycle after reset release
//   SAMPLE   | capture inputs; speed written on the edge leaving this state
//   APPLY    | speed from temperature bands just written; speed_set high
//   OVERRIDE | speed from manual override just written; speed_set high
//   4..7     | illegal, recover to IDLE
module fan_speed_controller
  import fan_ctrl_pkg::*;
#(
  parameter int LOW_MAX_DELTA = DEF_LOW_MAX_DELTA,
  parameter int MED_MAX_DELTA = DEF_MED_MAX_DELTA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] temperature_reading,
  input  logic [6:0] temperature_setpoint,
  input  logic       manual_override,
  input  logic       override_speed,
  output logic       speed_set,
  output logic [1:0] current_fan_speed,
  output logic [2:0] current_state
);

  state_e  state_q, state_d;
  speed_e  speed_q, speed_d;
  speed_e  dec_speed;
  logic    set_q, set_d;
  sample_t samp_q, samp_d;

  // Decode works on the values being captured this edge so the new speed
  // lands on the same edge that leaves SAMPLE.
  fan_speed_decode #(
    .LOW_MAX_DELTA (LOW_MAX_DELTA),
    .MED_MAX_DELTA (MED_MAX_DELTA)
  ) u_decode (
    .reading_i        (samp_d.reading),
    .setpoint_i       (samp_d.setpoint),
    .override_i       (samp_d.ovr),
    .override_speed_i (samp_d.ovr_speed),
    .speed_o          (dec_speed)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      speed_q <= SPEED_OFF;
      set_q   <= 1'b0;
      samp_q  <= '0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      set_q   <= set_d;
      samp_q  <= samp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    set_d   = 1'b0;
    samp_d  = samp_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        samp_d.reading   = temperature_reading;
        samp_d.setpoint  = temperature_setpoint;
        samp_d.ovr       = manual_override;
        samp_d.ovr_speed = override_speed;
        state_d          = manual_override ? ST_OVERRIDE : ST_APPLY;
        speed_d          = dec_speed;
        set_d            = 1'b1;
      end
      ST_APPLY, ST_OVERRIDE: begin
        state_d = ST_SAMPLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign speed_set         = set_q;
  assign current_fan_speed = speed_q;
  assign current_state     = state_q;

endmodule

// File: tb/tb_fan_speed_controller.sv
// Directed plus randomized checks of fan_speed_controller against a band model.
module tb_fan_speed_controller;

  localparam int LOW = 4;
  localparam int MED = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] rd = '0;
  logic [6:0] sp = '0;
  logic       ovr = 1'b0;
  logic       os = 1'b0;
  logic       speed_set;
  logic [1:0] speed;
  logic [2:0] state;

  int n_pass = 0;
  int n_total = 0;

  fan_speed_controller #(
    .LOW_MAX_DELTA (LOW),
    .MED_MAX_DELTA (MED)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .temperature_reading  (rd),
    .temperature_setpoint (sp),
    .manual_override      (ovr),
    .override_speed       (os),
    .speed_set            (speed_set),
    .current_fan_speed    (speed),
    .current_state        (state)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] model_speed(input int r, input int s, input bit m, input bit o);
    int d;
    d = r - s;
    if (m) return o ? 2'd3 : 2'd0;
    if (d <= 0) return 2'd0;
    if (d <= LOW) return 2'd1;
    if (d <= MED) return 2'd2;
    return 2'd3;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Two edges from a write point (or from release) reach the next write point.
  task automatic refresh(input string tag);
    tick();
    tick();
    check({tag, "_state"}, {5'd0, state}, ovr ? 8'd3 : 8'd2);
    check({tag, "_set"}, {7'd0, speed_set}, 8'd1);
    check({tag, "_speed"}, {6'd0, speed}, {6'd0, model_speed(rd, sp, ovr, os)});
  endtask

  initial begin
    int rlist[4];
    logic [2:0] exp_tr[5];
    rlist = '{74, 75, 79, 80};

    // reset state and OFF cases with a single speed_set pulse
    sp = 7'd70; rd = 7'd65;
    #1;
    check("rst_state", {5'd0, state}, 8'd0);
    check("rst_speed", {6'd0, speed}, 8'd0);
    check("rst_set", {7'd0, speed_set}, 8'd0);
    do_reset();
    check("rel_state", {5'd0, state}, 8'd0);
    tick();
    check("first_edge_state", {5'd0, state}, 8'd1);
    check("first_edge_set", {7'd0, speed_set}, 8'd0);
    tick();
    check("rd65_speed", {6'd0, speed}, 8'd0);
    check("rd65_set", {7'd0, speed_set}, 8'd1);
    tick();
    check("rd65_set_drop", {7'd0, speed_set}, 8'd0);
    rd = 7'd70;
    do_reset();
    tick(); tick();
    check("rd70_speed", {6'd0, speed}, 8'd0);
    check("rd70_set", {7'd0, speed_set}, 8'd1);

    // band boundaries, each from a fresh reset
    foreach (rlist[i]) begin
      rd = 7'(rlist[i]);
      do_reset();
      tick(); tick();
      check($sformatf("band_rd%0d", rlist[i]), {6'd0, speed}, {6'd0, model_speed(rd, sp, 1'b0, 1'b0)});
    end

    // override sequence mid-operation
    rd = 7'd80; ovr = 1'b1; os = 1'b0;
    refresh("ovr_off");
    os = 1'b1;
    refresh("ovr_high");
    ovr = 1'b0; rd = 7'd70;
    refresh("ovr_release");

    // state traces after release
    exp_tr = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd2};
    for (int pass = 0; pass < 2; pass++) begin
      ovr = (pass == 1);
      do_reset();
      for (int k = 0; k < 5; k++) begin
        if (k > 0) tick();
        check($sformatf("trace%0d_state%0d", pass, k), {5'd0, state},
              (ovr && exp_tr[k] == 3'd2) ? 8'd3 : {5'd0, exp_tr[k]});
        check($sformatf("trace%0d_set%0d", pass, k), {7'd0, speed_set},
              (exp_tr[k] == 3'd2) ? 8'd1 : 8'd0);
      end
    end
    ovr = 1'b0; os = 1'b0;

    // extremes
    rd = 7'd127; sp = 7'd0;
    do_reset();
    tick(); tick();
    check("ext_hot", {6'd0, speed}, 8'd3);
    rd = 7'd0; sp = 7'd127;
    do_reset();
    tick(); tick();
    check("ext_cold", {6'd0, speed}, 8'd0);

    // asynchronous reset while running at HIGH
    rd = 7'd127; sp = 7'd0;
    refresh("pre_abort");
    #2;
    reset = 1'b0;
    #1;
    check("abort_speed", {6'd0, speed}, 8'd0);
    check("abort_state", {5'd0, state}, 8'd0);
    check("abort_set", {7'd0, speed_set}, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    tick(); tick();
    check("abort_rerun", {6'd0, speed}, 8'd3);

    // randomized operating points, mostly clustered around the setpoint
    for (int n = 0; n < 40; n++) begin
      int r;
      sp = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 127);
      end else begin
        r = int'(sp) + $urandom_range(0, 14) - 2;
        if (r < 0) r = 0;
        if (r > 127) r = 127;
      end
      rd = 7'(r);
      ovr = ($urandom_range(0, 4) == 0);
      os = 1'($urandom_range(0, 1));
      refresh($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
